// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the RV32 core phase sequencer. The phase codes are
// also consumed by the debug/trace logic, so their numeric values are fixed.
// ----------------------------------------------------------------------------
package core_pkg;

    localparam int PHASE_W = 3;

    // Raw phase codes shared with the debug/trace logic
    localparam logic [PHASE_W-1:0] PHASE_IDLE   = 3'd0;
    localparam logic [PHASE_W-1:0] PHASE_FETCH  = 3'd1;
    localparam logic [PHASE_W-1:0] PHASE_DECODE = 3'd2;
    localparam logic [PHASE_W-1:0] PHASE_EXEC   = 3'd3;
    localparam logic [PHASE_W-1:0] PHASE_MEM    = 3'd4;
    localparam logic [PHASE_W-1:0] PHASE_WB     = 3'd5;
    localparam logic [PHASE_W-1:0] PHASE_HALT   = 3'd6;

    // Code 7 is deliberately left out; the sequencer treats it as illegal.
    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE   = PHASE_IDLE,
        PH_FETCH  = PHASE_FETCH,
        PH_DECODE = PHASE_DECODE,
        PH_EXEC   = PHASE_EXEC,
        PH_MEM    = PHASE_MEM,
        PH_WB     = PHASE_WB,
        PH_HALT   = PHASE_HALT
    } phase_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/core_phase_cnt.sv
// ----------------------------------------------------------------------------
// core_phase_cnt
// Loadable saturating up-counter with clear and terminal-compare outputs.
// Counts cycles spent in the current sequencer phase; it sticks at all-ones
// instead of wrapping so a long phase can never look like a fresh one.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear to 0 (highest priority)
//   load        synchronous load of load_val
//   load_val    value for load
//   inc         increment enable (saturating)
//   term_val    terminal value to compare against
//   count       current count
//   at_term     count == term_val
//   past_term   count >= term_val
// ----------------------------------------------------------------------------
module core_phase_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] term_val,
    output logic [W-1:0] count,
    output logic         at_term,
    output logic         past_term
);

    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + W'(1);
        end
    end

    assign at_term   = (count == term_val);
    assign past_term = (count >= term_val);

endmodule

// File: rtl/core_phase_seq.sv
// ----------------------------------------------------------------------------
// core_phase_seq
// Multi-cycle phase sequencer for the RV32 core. Produces single-clock phase
// enables (fetch, register read, ALU start, RAM, write-back, PC update),
// honours variable-latency ALU completion and RAM wait states, and supports
// halt/resume at instruction boundaries.
//
// Optional feature macro: PERF_CNT_EN builds the retired / stall counters;
// without it both counter outputs are constant 0.
//
// Ports:
//   clk, rst_n         core clock, asynchronous active-low reset
//   alu_multi          instruction needs multi-cycle ALU (sampled in DECODE)
//   alu_complete       ALU result valid
//   mem_access         instruction is load/store (sampled in DECODE)
//   mem_ready          RAM access done
//   halt_req           stop at next instruction boundary
//   fetch_en           PC/ROM capture enable (last FETCH cycle)
//   reg_rd_en          register-file read strobe (DECODE)
//   alu_start          ALU start pulse (first EXEC cycle)
//   ram_en             RAM access enable (every MEM cycle)
//   reg_wr_en, pc_en   write-back and PC update strobes (WB)
//   phase              current phase code
//   halted             sequencer is in HALT
//   timeout_err        sticky ALU timeout flag
//   retired            retired instruction count
//   stall_cycles       ALU/MEM wait cycles
// ----------------------------------------------------------------------------
module core_phase_seq
    import core_pkg::*;
#(
    parameter int FETCH_CYCLES   = 1,
    parameter int MEM_MIN_CYCLES = 1,
    parameter int ALU_TIMEOUT    = 64,
    parameter int CNT_W          = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alu_multi,
    input  logic               alu_complete,
    input  logic               mem_access,
    input  logic               mem_ready,
    input  logic               halt_req,
    output logic               fetch_en,
    output logic               reg_rd_en,
    output logic               alu_start,
    output logic               ram_en,
    output logic               reg_wr_en,
    output logic               pc_en,
    output logic [PHASE_W-1:0] phase,
    output logic               halted,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   retired,
    output logic [CNT_W-1:0]   stall_cycles
);

    localparam int PC_W = $clog2(max3(FETCH_CYCLES, MEM_MIN_CYCLES, ALU_TIMEOUT) + 1);

    phase_e          ph_q;
    phase_e          ph_nxt;
    logic [PC_W-1:0] ph_cnt;
    logic [PC_W-1:0] term_val;
    logic            at_term;
    logic            past_term;
    logic            alu_multi_q;
    logic            mem_access_q;
    logic            alu_to;
    logic            fetch_last_nxt;

    // ph_cnt is the number of cycles already spent in the current phase, so
    // it reads 0 on the first cycle of every phase.
    core_phase_cnt #(
        .W (PC_W)
    ) u_phase_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (ph_nxt != ph_q),
        .load      (1'b0),
        .load_val  ('0),
        .inc       (1'b1),
        .term_val  (term_val),
        .count     (ph_cnt),
        .at_term   (at_term),
        .past_term (past_term)
    );

    always_comb begin
        case (ph_q)
            PH_FETCH: term_val = PC_W'(FETCH_CYCLES - 1);
            PH_MEM:   term_val = PC_W'(MEM_MIN_CYCLES - 1);
            default:  term_val = PC_W'(ALU_TIMEOUT - 1);
        endcase
    end

    always_comb begin
        ph_nxt = ph_q;
        alu_to = 1'b0;
        case (ph_q)
            PH_IDLE:   ph_nxt = PH_FETCH;
            PH_FETCH:  if (at_term) ph_nxt = PH_DECODE;
            PH_DECODE: ph_nxt = PH_EXEC;
            PH_EXEC: begin
                // alu_complete wins over the timeout on the same cycle
                alu_to = alu_multi_q && !alu_complete && at_term;
                if (!alu_multi_q || alu_complete || at_term)
                    ph_nxt = mem_access_q ? PH_MEM : PH_WB;
            end
            PH_MEM:    if (mem_ready && past_term) ph_nxt = PH_WB;
            PH_WB:     ph_nxt = halt_req ? PH_HALT : PH_FETCH;
            PH_HALT:   if (!halt_req) ph_nxt = PH_FETCH;
            default:   ph_nxt = PH_IDLE;
        endcase
    end

    // fetch_en is registered, so predict whether the coming cycle is the last
    // FETCH cycle: either a fresh one-cycle FETCH, or one short of the end.
    always_comb begin
        fetch_last_nxt = 1'b0;
        if (ph_nxt == PH_FETCH) begin
            if (ph_q != PH_FETCH)
                fetch_last_nxt = (FETCH_CYCLES == 1);
            else
                fetch_last_nxt = (int'(ph_cnt) == FETCH_CYCLES - 2);
        end
    end

    // Phase register and strobes, all decoded from the next phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q         <= PH_IDLE;
            fetch_en     <= 1'b0;
            reg_rd_en    <= 1'b0;
            alu_start    <= 1'b0;
            ram_en       <= 1'b0;
            reg_wr_en    <= 1'b0;
            pc_en        <= 1'b0;
            halted       <= 1'b0;
            timeout_err  <= 1'b0;
            alu_multi_q  <= 1'b0;
            mem_access_q <= 1'b0;
        end else begin
            ph_q      <= ph_nxt;
            fetch_en  <= fetch_last_nxt;
            reg_rd_en <= (ph_nxt == PH_DECODE);
            alu_start <= (ph_nxt == PH_EXEC) && (ph_q != PH_EXEC);
            ram_en    <= (ph_nxt == PH_MEM);
            reg_wr_en <= (ph_nxt == PH_WB);
            pc_en     <= (ph_nxt == PH_WB);
            halted    <= (ph_nxt == PH_HALT);
            if (alu_to)
                timeout_err <= 1'b1;
            if (ph_q == PH_DECODE) begin
                alu_multi_q  <= alu_multi;
                mem_access_q <= mem_access;
            end
        end
    end

    assign phase = ph_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (ph_q == PH_WB)
                retired_q <= retired_q + CNT_W'(1);
            // Every EXEC/MEM cycle beyond the first is a wait cycle
            if (((ph_q == PH_EXEC) || (ph_q == PH_MEM)) && (ph_cnt != '0))
                stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign retired      = retired_q;
    assign stall_cycles = stall_q;
`else
    assign retired      = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_core_phase_seq.sv
module tb_core_phase_seq;

    logic        clk;
    logic        rst_n;
    logic        alu_multi, alu_complete, mem_access, mem_ready, halt_req;

    logic        fetch_en, reg_rd_en, alu_start, ram_en, reg_wr_en, pc_en, halted, timeout_err;
    logic [2:0]  phase;
    logic [31:0] retired, stall_cycles;

    logic        d2_fetch_en, d2_reg_rd_en, d2_alu_start, d2_ram_en, d2_reg_wr_en, d2_pc_en;
    logic        d2_halted, d2_timeout_err;
    logic [2:0]  d2_phase;
    logic [15:0] d2_retired, d2_stall_cycles;

    int checks = 0;
    int errors = 0;

    core_phase_seq #(
        .FETCH_CYCLES(1), .MEM_MIN_CYCLES(2), .ALU_TIMEOUT(64), .CNT_W(32)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .alu_multi(alu_multi), .alu_complete(alu_complete),
        .mem_access(mem_access), .mem_ready(mem_ready), .halt_req(halt_req),
        .fetch_en(fetch_en), .reg_rd_en(reg_rd_en), .alu_start(alu_start),
        .ram_en(ram_en), .reg_wr_en(reg_wr_en), .pc_en(pc_en),
        .phase(phase), .halted(halted), .timeout_err(timeout_err),
        .retired(retired), .stall_cycles(stall_cycles)
    );

    core_phase_seq #(
        .FETCH_CYCLES(3), .MEM_MIN_CYCLES(1), .ALU_TIMEOUT(4), .CNT_W(16)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .alu_multi(alu_multi), .alu_complete(alu_complete),
        .mem_access(mem_access), .mem_ready(mem_ready), .halt_req(halt_req),
        .fetch_en(d2_fetch_en), .reg_rd_en(d2_reg_rd_en), .alu_start(d2_alu_start),
        .ram_en(d2_ram_en), .reg_wr_en(d2_reg_wr_en), .pc_en(d2_pc_en),
        .phase(d2_phase), .halted(d2_halted), .timeout_err(d2_timeout_err),
        .retired(d2_retired), .stall_cycles(d2_stall_cycles)
    );

    wire [6:0] stb = {fetch_en, reg_rd_en, alu_start, ram_en, reg_wr_en, pc_en, halted};

    localparam logic [6:0] S_0 = 7'b0000000;
    localparam logic [6:0] S_F = 7'b1000000;
    localparam logic [6:0] S_R = 7'b0100000;
    localparam logic [6:0] S_A = 7'b0010000;
    localparam logic [6:0] S_M = 7'b0001000;
    localparam logic [6:0] S_W = 7'b0000110;
    localparam logic [6:0] S_H = 7'b0000001;

    typedef struct {
        logic       am, ac, ma, mr, hr;
        logic [2:0] ph;
        logic [6:0] stb;
        int         ret;
        int         stl;
    } row_t;

    row_t tbl[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pexp(input int v);
`ifdef PERF_CNT_EN
        return 32'(v);
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic add(input logic am, input logic ac, input logic ma, input logic mr,
                       input logic hr, input logic [2:0] ph, input logic [6:0] s,
                       input int ret, input int stl);
        row_t r;
        r.am = am; r.ac = ac; r.ma = ma; r.mr = mr; r.hr = hr;
        r.ph = ph; r.stb = s; r.ret = ret; r.stl = stl;
        tbl.push_back(r);
    endtask

    task automatic drive(input logic am, input logic ac, input logic ma, input logic mr, input logic hr);
        alu_multi = am; alu_complete = ac; mem_access = ma; mem_ready = mr; halt_req = hr;
    endtask

    task automatic wait_phase(input logic [2:0] ph, input int budget);
        bit found;
        found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            @(negedge clk);
            if (phase == ph) found = 1'b1;
        end
        chk($sformatf("wait_phase_%0d", ph), {31'd0, found}, 32'd1);
    endtask

    initial begin
        int exp1_ph [8]  = '{0, 1, 2, 3, 5, 1, 2, 3};
        int exp2_ph [8]  = '{0, 1, 1, 1, 2, 3, 5, 1};
        int exp2_fe [8]  = '{0, 0, 0, 1, 0, 0, 0, 0};
        int to2_ph  [11] = '{0, 1, 1, 1, 2, 3, 3, 3, 3, 5, 1};
        int to2_err [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        int to2_as  [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

        // Plain ALU instruction: 4-cycle period
        add(0,0,0,0,0, 3'd0, S_0, 0, 0);
        add(0,0,0,0,0, 3'd1, S_F, 0, 0);
        add(0,0,0,0,0, 3'd2, S_R, 0, 0);
        add(0,0,0,0,0, 3'd3, S_A, 0, 0);
        add(0,0,0,0,0, 3'd5, S_W, 0, 0);
        // Multi-cycle ALU, complete on third EXEC cycle
        add(0,0,0,0,0, 3'd1, S_F, 1, 0);
        add(1,0,0,0,0, 3'd2, S_R, 1, 0);
        add(0,0,0,0,0, 3'd3, S_A, 1, 0);
        add(0,0,0,0,0, 3'd3, S_0, 1, 0);
        add(0,1,0,0,0, 3'd3, S_0, 1, 1);
        add(0,0,0,0,0, 3'd5, S_W, 1, 2);
        // Memory access, mem_ready from first MEM cycle, minimum of 2
        add(0,0,0,0,0, 3'd1, S_F, 2, 2);
        add(0,0,1,0,0, 3'd2, S_R, 2, 2);
        add(0,0,0,0,0, 3'd3, S_A, 2, 2);
        add(0,0,0,1,0, 3'd4, S_M, 2, 2);
        add(0,0,0,1,0, 3'd4, S_M, 2, 2);
        add(0,0,0,0,0, 3'd5, S_W, 2, 3);
        // Multi ALU done immediately, early mem_ready not remembered
        add(0,0,0,0,0, 3'd1, S_F, 3, 3);
        add(1,0,1,0,0, 3'd2, S_R, 3, 3);
        add(0,1,0,0,0, 3'd3, S_A, 3, 3);
        add(0,0,0,1,0, 3'd4, S_M, 3, 3);
        add(0,0,0,0,0, 3'd4, S_M, 3, 3);
        add(0,0,0,1,0, 3'd4, S_M, 3, 4);
        add(0,0,0,0,0, 3'd5, S_W, 3, 5);
        // halt_req raised in EXEC, held 10 cycles
        add(0,0,0,0,0, 3'd1, S_F, 4, 5);
        add(0,0,0,0,0, 3'd2, S_R, 4, 5);
        add(0,0,0,0,1, 3'd3, S_A, 4, 5);
        add(0,0,0,0,1, 3'd5, S_W, 4, 5);
        for (int i = 0; i < 8; i++) add(0,0,0,0,1, 3'd6, S_H, 5, 5);
        add(0,0,0,0,0, 3'd6, S_H, 5, 5);
        add(0,0,0,0,0, 3'd1, S_F, 5, 5);
        add(0,0,0,0,0, 3'd2, S_R, 5, 5);
        add(0,0,0,0,0, 3'd3, S_A, 5, 5);
        add(0,0,0,0,0, 3'd5, S_W, 5, 5);
        add(0,0,0,0,0, 3'd1, S_F, 6, 5);

        // Reset state
        rst_n = 1'b0;
        drive(0,0,0,0,0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_strobes", 32'(stb), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_stall", stall_cycles, 32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            if (i > 0) @(negedge clk);
            drive(tbl[i].am, tbl[i].ac, tbl[i].ma, tbl[i].mr, tbl[i].hr);
            chk($sformatf("row%0d_phase", i), 32'(phase), 32'(tbl[i].ph));
            chk($sformatf("row%0d_strobes", i), 32'(stb), 32'(tbl[i].stb));
            chk($sformatf("row%0d_retired", i), retired, pexp(tbl[i].ret));
            chk($sformatf("row%0d_stall", i), stall_cycles, pexp(tbl[i].stl));
        end

        // ALU timeout: 64 EXEC cycles, then sticky error
        @(negedge clk);
        drive(1,0,0,0,0);
        chk("to_decode", 32'(phase), 32'd2);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            drive(0,0,0,0,0);
            chk($sformatf("to_exec%0d_phase", i), 32'(phase), 32'd3);
            chk($sformatf("to_exec%0d_alu_start", i), 32'(alu_start), (i == 0) ? 32'd1 : 32'd0);
        end
        chk("to_err_during_exec", 32'(timeout_err), 32'd0);
        @(negedge clk);
        chk("to_exit_wb", 32'(phase), 32'd5);
        chk("to_err_set", 32'(timeout_err), 32'd1);

        // Next instruction goes to MEM with mem_ready low; reset mid-MEM
        drive(0,0,1,0,0);
        wait_phase(3'd4, 10);
        chk("mem_ram_en", 32'(ram_en), 32'd1);
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_phase", 32'(phase), 32'd0);
        chk("arst_strobes", 32'(stb), 32'd0);
        chk("arst_timeout_err", 32'(timeout_err), 32'd0);
        chk("arst_retired", retired, 32'd0);
        chk("arst_stall", stall_cycles, 32'd0);
        @(posedge clk);
        #1;
        chk("arst_hold_phase", 32'(phase), 32'd0);
        @(negedge clk);
        drive(0,0,0,0,0);
        rst_n = 1'b1;

        // Clean restart on both instances; FETCH_CYCLES=3 on the second
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("rs%0d_phase", i), 32'(phase), 32'(exp1_ph[i]));
            chk($sformatf("rs%0d_d2_phase", i), 32'(d2_phase), 32'(exp2_ph[i]));
            chk($sformatf("rs%0d_d2_fetch_en", i), 32'(d2_fetch_en), 32'(exp2_fe[i]));
        end

        // Short ALU timeout on the second instance
        rst_n = 1'b0;
        drive(1,0,0,0,0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("t2_%0d_phase", i), 32'(d2_phase), 32'(to2_ph[i]));
            chk($sformatf("t2_%0d_err", i), 32'(d2_timeout_err), 32'(to2_err[i]));
            chk($sformatf("t2_%0d_alu_start", i), 32'(d2_alu_start), 32'(to2_as[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
